// File: rtl/cond_code_unit.sv
// -----------------------------------------------------------------------------
// cond_code_unit
//
// Condition-code register plus condition evaluator. ALU flags {Z,N,C,V} are
// latched when the execute-stage instruction sets S. The registered carry is
// returned to the ALU as Cin. The decode-stage condition field is evaluated
// into a registered result, qualified by a one-cycle Cond_done pulse.
//
// Build option: define COND_FWD_EN to forward same-cycle Flags_in into the
// evaluation (latency always 1, Hazard tied 0). When it is undefined, a
// condition that arrives together with S waits one cycle in WAIT, so that it
// sees the updated flag register (latency 2, Hazard high for one cycle).
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   Flags_in    in   [3:0] ALU flags: [3]=Z [2]=N [1]=C [0]=V
//   S           in   execute instruction updates the condition codes
//   Cond        in   [3:0] condition field of the decode instruction
//   Cond_valid  in   Cond requests evaluation
//   Stall       in   pipeline hold, freezes all state
//   Flags_q     out  [3:0] registered condition codes
//   Cin         out  registered carry (Flags_q[1])
//   Cond_true   out  registered result of the last evaluation
//   Cond_done   out  one-cycle pulse, Cond_true newly valid
//   Hazard      out  evaluation delayed by one cycle
// -----------------------------------------------------------------------------
module cond_code_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Flags_in,
    input  logic       S,
    input  logic [3:0] Cond,
    input  logic       Cond_valid,
    input  logic       Stall,
    output logic [3:0] Flags_q,
    output logic       Cin,
    output logic       Cond_true,
    output logic       Cond_done,
    output logic       Hazard
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t     state_q,     state_d;
    logic [3:0] flags_q,     flags_d;
    logic [3:0] cond_hold_q, cond_hold_d;
    logic       cond_true_q, cond_true_d;
    logic       cond_done_q, cond_done_d;

    logic [3:0] eval_flags;
    logic       take_wait;

    // Evaluate a 4-bit condition code against a flag set {Z,N,C,V}.
    function automatic logic cond_eval(input logic [3:0] cond,
                                       input logic [3:0] f);
        logic z, n, c, v;
        logic r;
        z = f[3];
        n = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'd0:    r = z;
            4'd1:    r = !z;
            4'd2:    r = c;
            4'd3:    r = !c;
            4'd4:    r = n;
            4'd5:    r = !n;
            4'd6:    r = v;
            4'd7:    r = !v;
            4'd8:    r = c & !z;
            4'd9:    r = !c | z;
            4'd10:   r = (n == v);
            4'd11:   r = (n != v);
            4'd12:   r = !z & (n == v);
            4'd13:   r = z | (n != v);
            4'd14:   r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Flag source and hazard decision for a condition accepted in IDLE.
    always_comb begin
`ifdef COND_FWD_EN
        eval_flags = S ? Flags_in : flags_q;
        take_wait  = 1'b0;
`else
        eval_flags = flags_q;
        take_wait  = S;
`endif
    end

    // Next-state logic. A stalled cycle leaves every register unchanged,
    // including the done flag, whose visible pulse is masked at the output
    // until the stall clears so that it is still reported exactly once.
    always_comb begin
        state_d     = state_q;
        flags_d     = flags_q;
        cond_hold_d = cond_hold_q;
        cond_true_d = cond_true_q;
        cond_done_d = cond_done_q;

        if (!Stall) begin
            cond_done_d = 1'b0;
            if (S) begin
                flags_d = Flags_in;
            end
            if (state_q == WAIT) begin
                // Flag register already holds the update that caused the wait.
                cond_true_d = cond_eval(cond_hold_q, flags_q);
                cond_done_d = 1'b1;
                state_d     = IDLE;
            end else if (Cond_valid) begin
                if (take_wait) begin
                    cond_hold_d = Cond;
                    state_d     = WAIT;
                end else begin
                    cond_true_d = cond_eval(Cond, eval_flags);
                    cond_done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            flags_q     <= 4'b0000;
            cond_true_q <= 1'b0;
            cond_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            cond_true_q <= cond_true_d;
            cond_done_q <= cond_done_d;
        end
    end

    // Captured condition is only meaningful while in WAIT; it needs no reset.
    always_ff @(posedge clk) begin
        cond_hold_q <= cond_hold_d;
    end

    assign Flags_q   = flags_q;
    assign Cin       = flags_q[1];
    assign Cond_true = cond_true_q;
    assign Cond_done = cond_done_q & ~Stall;

`ifdef COND_FWD_EN
    assign Hazard = 1'b0;
`else
    assign Hazard = (state_q == WAIT);
`endif

endmodule

// File: tb/tb_cond_code_unit.sv
module tb_cond_code_unit;

    logic       clk;
    logic       reset;
    logic [3:0] Flags_in;
    logic       S;
    logic [3:0] Cond;
    logic       Cond_valid;
    logic       Stall;
    logic [3:0] Flags_q;
    logic       Cin;
    logic       Cond_true;
    logic       Cond_done;
    logic       Hazard;

    int n_cmp;
    int n_err;
    int done_cnt;
    bit exp_q[$];

    cond_code_unit dut (
        .clk       (clk),
        .reset     (reset),
        .Flags_in  (Flags_in),
        .S         (S),
        .Cond      (Cond),
        .Cond_valid(Cond_valid),
        .Stall     (Stall),
        .Flags_q   (Flags_q),
        .Cin       (Cin),
        .Cond_true (Cond_true),
        .Cond_done (Cond_done),
        .Hazard    (Hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every Cond_done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (Cond_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            n_cmp = n_cmp + 1;
            if (exp_q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL scoreboard_unexpected_done: Cond_true=%0b with no evaluation pending", Cond_true);
            end else begin
                bit e;
                e = exp_q.pop_front();
                if (Cond_true !== e) begin
                    n_err = n_err + 1;
                    $display("FAIL scoreboard_cond_true: got %0b expected %0b", Cond_true, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        S          = 1'b0;
        Flags_in   = 4'b0000;
        Cond       = 4'd0;
        Cond_valid = 1'b0;
        Stall      = 1'b0;
    endtask

    task automatic load_flags(input logic [3:0] f);
        S        = 1'b1;
        Flags_in = f;
        cyc();
        S        = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 10) begin
            cyc();
            k++;
        end
        cyc();
        n_cmp = n_cmp + 1;
        if (exp_q.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL %s_drain: %0d evaluations still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            Flags_in   = 4'($urandom);
            S          = 1'($urandom);
            Cond       = 4'($urandom);
            Cond_valid = 1'($urandom);
            Stall      = 1'($urandom);
            cyc();
        end
        n_cmp = n_cmp + 5;
        if (Flags_q !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b expected 0000", Flags_q); end
        if (Cin !== 1'b0)        begin n_err++; $display("FAIL reset_cin: got %b expected 0", Cin); end
        if (Cond_true !== 1'b0)  begin n_err++; $display("FAIL reset_cond_true: got %b expected 0", Cond_true); end
        if (Cond_done !== 1'b0)  begin n_err++; $display("FAIL reset_cond_done: got %b expected 0", Cond_done); end
        if (Hazard !== 1'b0)     begin n_err++; $display("FAIL reset_hazard: got %b expected 0", Hazard); end
        idle_inputs();
        reset = 1'b0;
        exp_q.delete();
        cyc();
    endtask

    task automatic test_flag_sweep();
        logic [15:0] table_v;
        int d0;
        table_v = 16'b0110_1001_1001_0110; // bit c = expected result of Cond c
        load_flags(4'b0110);
        n_cmp = n_cmp + 2;
        if (Flags_q !== 4'b0110) begin n_err++; $display("FAIL sweep_flags: got %b expected 0110", Flags_q); end
        if (Cin !== 1'b1)        begin n_err++; $display("FAIL sweep_cin: got %b expected 1", Cin); end
        d0 = done_cnt;
        for (int c = 0; c < 16; c++) begin
            Cond       = 4'(c);
            Cond_valid = 1'b1;
            exp_q.push_back(table_v[c]);
            cyc();
        end
        Cond_valid = 1'b0;
        drain("sweep");
        n_cmp = n_cmp + 1;
        if (done_cnt - d0 !== 16) begin
            n_err++;
            $display("FAIL sweep_done_count: got %0d expected 16", done_cnt - d0);
        end
    endtask

    task automatic test_stall();
        int d0;
        load_flags(4'b0000);
        d0 = done_cnt;
        Stall      = 1'b1;
        S          = 1'b1;
        Flags_in   = 4'b1000;
        Cond_valid = 1'b1;
        Cond       = 4'd0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp = n_cmp + 2;
            if (Flags_q !== 4'b0000) begin n_err++; $display("FAIL stall_flags: got %b expected 0000", Flags_q); end
            if (Cond_done !== 1'b0)  begin n_err++; $display("FAIL stall_done: got %b expected 0", Cond_done); end
        end
        Stall = 1'b0;
        exp_q.push_back(1'b1);
        cyc();
        S          = 1'b0;
        Cond_valid = 1'b0;
        drain("stall");
        cyc();
        n_cmp = n_cmp + 2;
        if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL stall_done_count: got %0d expected 1", done_cnt - d0); end
        if (Flags_q !== 4'b1000) begin n_err++; $display("FAIL stall_flags_after: got %b expected 1000", Flags_q); end
    endtask

    task automatic test_same_cycle_hazard();
        load_flags(4'b0000);
        S          = 1'b1;
        Flags_in   = 4'b1000;
        Cond_valid = 1'b1;
        Cond       = 4'd0;
        exp_q.push_back(1'b1);
        cyc();
        S          = 1'b0;
        Cond_valid = 1'b0;
`ifdef COND_FWD_EN
        n_cmp = n_cmp + 3;
        if (Hazard !== 1'b0)    begin n_err++; $display("FAIL fwd_hazard: got %b expected 0", Hazard); end
        if (Cond_done !== 1'b1) begin n_err++; $display("FAIL fwd_done: got %b expected 1", Cond_done); end
        if (Cond_true !== 1'b1) begin n_err++; $display("FAIL fwd_true: got %b expected 1", Cond_true); end
`else
        n_cmp = n_cmp + 2;
        if (Hazard !== 1'b1)    begin n_err++; $display("FAIL hz_hazard: got %b expected 1", Hazard); end
        if (Cond_done !== 1'b0) begin n_err++; $display("FAIL hz_early_done: got %b expected 0", Cond_done); end
        cyc();
        n_cmp = n_cmp + 3;
        if (Hazard !== 1'b0)    begin n_err++; $display("FAIL hz_hazard_clear: got %b expected 0", Hazard); end
        if (Cond_done !== 1'b1) begin n_err++; $display("FAIL hz_done: got %b expected 1", Cond_done); end
        if (Cond_true !== 1'b1) begin n_err++; $display("FAIL hz_true: got %b expected 1", Cond_true); end
`endif
        drain("hazard");
    endtask

`ifndef COND_FWD_EN
    task automatic test_reset_mid_hazard();
        int d0;
        load_flags(4'b0000);
        d0 = done_cnt;
        S          = 1'b1;
        Flags_in   = 4'b1000;
        Cond_valid = 1'b1;
        Cond       = 4'd0;
        cyc();
        S          = 1'b0;
        Cond_valid = 1'b0;
        n_cmp = n_cmp + 1;
        if (Hazard !== 1'b1) begin n_err++; $display("FAIL rmh_hazard: got %b expected 1", Hazard); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_cmp = n_cmp + 5;
        if (Flags_q !== 4'b0000) begin n_err++; $display("FAIL rmh_flags: got %b expected 0000", Flags_q); end
        if (Cin !== 1'b0)        begin n_err++; $display("FAIL rmh_cin: got %b expected 0", Cin); end
        if (Cond_true !== 1'b0)  begin n_err++; $display("FAIL rmh_true: got %b expected 0", Cond_true); end
        if (Cond_done !== 1'b0)  begin n_err++; $display("FAIL rmh_done: got %b expected 0", Cond_done); end
        if (Hazard !== 1'b0)     begin n_err++; $display("FAIL rmh_hazard_clear: got %b expected 0", Hazard); end
        cyc();
        cyc();
        n_cmp = n_cmp + 1;
        if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL rmh_done_count: got %0d expected 0", done_cnt - d0); end
    endtask
`endif

    task automatic test_signed_compare();
        logic [3:0] exp_v;
        exp_v = 4'b1010; // bit i = expected result of Cond 10+i
        load_flags(4'b0001);
        for (int i = 0; i < 4; i++) begin
            Cond       = 4'(10 + i);
            Cond_valid = 1'b1;
            exp_q.push_back(exp_v[i]);
            cyc();
        end
        Cond_valid = 1'b0;
        drain("signed");
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        done_cnt = 0;
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_flag_sweep();
        test_stall();
        test_same_cycle_hazard();
`ifndef COND_FWD_EN
        test_reset_mid_hazard();
`endif
        test_signed_compare();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
